// File: rtl/aes_entry_sequencer_pkg.sv
// Shared definitions for the AES entry sequencer.
// Contents: state encoding (also the LED state_idx value), step strobe bit
// indices so the wrapper glue can map strobes to datapath loads by name, and
// a helper that builds a one-hot strobe word from a state index.
package aes_entry_sequencer_pkg;

    localparam int unsigned StepWidth  = 14;
    localparam int unsigned StateWidth = 5;

    // Entry states 0..13 double as the index of the strobe they emit.
    typedef enum logic [4:0] {
        StV0    = 5'd0,
        StV1    = 5'd1,
        StV2    = 5'd2,
        StV3    = 5'd3,
        StM0    = 5'd4,
        StM1    = 5'd5,
        StM2    = 5'd6,
        StM3    = 5'd7,
        StK0    = 5'd8,
        StK1    = 5'd9,
        StK2    = 5'd10,
        StK3    = 5'd11,
        StRon   = 5'd12,
        StStart = 5'd13,
        StWait  = 5'd14,
        StDisp  = 5'd15,
        StErr   = 5'd16
    } seq_state_e;

    localparam int unsigned STEP_V0    = 0;
    localparam int unsigned STEP_V1    = 1;
    localparam int unsigned STEP_V2    = 2;
    localparam int unsigned STEP_V3    = 3;
    localparam int unsigned STEP_M0    = 4;
    localparam int unsigned STEP_M1    = 5;
    localparam int unsigned STEP_M2    = 6;
    localparam int unsigned STEP_M3    = 7;
    localparam int unsigned STEP_K0    = 8;
    localparam int unsigned STEP_K1    = 9;
    localparam int unsigned STEP_K2    = 10;
    localparam int unsigned STEP_K3    = 11;
    localparam int unsigned STEP_RON   = 12;
    localparam int unsigned STEP_START = 13;

    function automatic logic [StepWidth-1:0] step_onehot(input logic [StateWidth-1:0] idx);
        logic [StepWidth-1:0] one;
        one = StepWidth'(1);
        return one << idx;
    endfunction

endpackage

// File: rtl/aes_entry_sequencer_if.sv
// Board/datapath signal bundle of the AES entry sequencer.
// master: drives btn_next, btn_clr, finished; observes the outputs.
// slave : the sequencer; consumes buttons and finished, drives
//         step[13:0], disp, busy, error, state_idx[4:0].
interface aes_entry_sequencer_if;
    import aes_entry_sequencer_pkg::*;

    logic                  btn_next;
    logic                  btn_clr;
    logic                  finished;
    logic [StepWidth-1:0]  step;
    logic                  disp;
    logic                  busy;
    logic                  error;
    logic [StateWidth-1:0] state_idx;

    modport master (
        output btn_next, btn_clr, finished,
        input  step, disp, busy, error, state_idx
    );

    modport slave (
        input  btn_next, btn_clr, finished,
        output step, disp, busy, error, state_idx
    );

endinterface

// File: rtl/aes_entry_sequencer_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, press pulse.
// Ports: clk, nrst (async active-low), btn (raw asynchronous button),
//        press (one-cycle pulse when the debounced level goes 0->1).
// The debounced level flips only after the synchronised input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts.
module aes_entry_sequencer_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            press_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                    // Only the 0->1 flip produces a press.
                    press_q <= sync2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/aes_entry_sequencer.sv
// AES entry sequencer: turns two debounced buttons into one-hot datapath
// step strobes (v0..v3, m0..m3, k0..k3, ron, start_enc), waits for the core
// to finish, then holds the display request.
// Ports: clk, nrst (async active-low), bus (slave modport):
//   btn_next/btn_clr raw buttons, finished core flag in;
//   step[13:0] strobes, disp level, busy (WAIT), error (ERR),
//   state_idx[4:0] current state out.
// Optional: AES_SEQ_TIMEOUT_EN adds a WAIT timeout of TIMEOUT_CYCLES into ERR;
// without it ERR is unreachable and error is tied low.
module aes_entry_sequencer
    import aes_entry_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic                  clk,
    input  logic                  nrst,
    aes_entry_sequencer_if.slave  bus
);

    logic                 next_press;
    logic                 clr_press;
    logic                 fin_q;
    logic                 fin_rise;
    seq_state_e           state_q;
    logic [StepWidth-1:0] step_q;
    logic                 disp_q;
    logic                 busy_q;

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic            err_q;
    logic [TmoW-1:0] tmo_q;
`endif

    aes_entry_sequencer_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_next_db (
        .clk   (clk),
        .nrst  (nrst),
        .btn   (bus.btn_next),
        .press (next_press)
    );

    aes_entry_sequencer_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr_db (
        .clk   (clk),
        .nrst  (nrst),
        .btn   (bus.btn_clr),
        .press (clr_press)
    );

    // A finished level left high from a previous run never counts as an edge.
    assign fin_rise = bus.finished & ~fin_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StV0;
            step_q  <= '0;
            disp_q  <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
            tmo_q   <= '0;
`endif
        end else begin
            fin_q  <= bus.finished;
            step_q <= '0;
            if (clr_press) begin
                // Restart wins over everything, including a simultaneous next.
                state_q <= StV0;
                disp_q  <= 1'b0;
                busy_q  <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
                err_q   <= 1'b0;
`endif
            end else begin
                case (state_q)
                    StWait: begin
                        if (fin_rise) begin
                            state_q <= StDisp;
                            busy_q  <= 1'b0;
                            disp_q  <= 1'b1;
                        end
`ifdef AES_SEQ_TIMEOUT_EN
                        else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                            state_q <= StErr;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
`endif
                    end
                    StDisp: begin
                        if (next_press) begin
                            state_q <= StV0;
                            disp_q  <= 1'b0;
                        end
                    end
                    StErr: begin
                        if (next_press) begin
                            state_q <= StV0;
`ifdef AES_SEQ_TIMEOUT_EN
                            err_q   <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        // Entry states: emit the strobe named by the state index.
                        if (next_press) begin
                            step_q <= step_onehot(state_q);
                            if (state_q == StStart) begin
                                state_q <= StWait;
                                busy_q  <= 1'b1;
`ifdef AES_SEQ_TIMEOUT_EN
                                tmo_q   <= '0;
`endif
                            end else begin
                                state_q <= seq_state_e'(state_q + 5'd1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.step      = step_q;
    assign bus.disp      = disp_q;
    assign bus.busy      = busy_q;
    assign bus.state_idx = state_q;
`ifdef AES_SEQ_TIMEOUT_EN
    assign bus.error     = err_q;
`else
    assign bus.error     = 1'b0;
`endif

endmodule

// File: doc/aes_entry_sequencer.md
Name: aes_entry_sequencer

Overview:
Upstream control stage for the AES wrapper datapath.
- Turns two raw board buttons into the one-hot step strobes the datapath consumes: v0..v3, m0..m3, k0..k3, ron and start_enc, plus the level disp.
- Walks the operator through entering the vector, message, key and round number nibble by nibble, launches the encryption, waits for finished, then holds the display request.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz)
TIMEOUT_CYCLES, 4096, maximum cycles spent in WAIT before error (used only with the optional feature)

Ports:
clk  input  1  system clock
nrst  input  1  reset; one clock; reset is asynchronous and active-low
btn_next  input  1  raw asynchronous "advance" button
btn_clr  input  1  raw asynchronous "restart" button
finished  input  1  AES core completion flag
step  output  14  one-cycle strobes: [3:0]=v0..v3, [7:4]=m0..m3, [11:8]=k0..k3, [12]=ron, [13]=start_enc
disp  output  1  display request level (drives datapath disp)
busy  output  1  high while in WAIT
error  output  1  high while in ERR
state_idx  output  5  current state encoding, for LEDs

Behaviour:
- Reset (async, nrst=0): state=V0; step=0, disp=0, busy=0, error=0, state_idx=0; debounce counters and edge registers cleared. Assertion mid-strobe kills the strobe immediately.
- Button path, per button:
  - 2-flop synchroniser, then counter.
  - Debounced level flips only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - press = one-cycle pulse on the debounced 0->1 edge. Release generates nothing.
- States and state_idx values: V0..V3=0..3, M0..M3=4..7, K0..K3=8..11, RON=12, START=13, WAIT=14, DISP=15, ERR=16.
- Entry states 0..13:
  - On next press, step[state_idx] is 1 for exactly the following cycle (registered), and the state advances by one.
  - START emits step[13] (start_enc) and moves to WAIT.
- Only one step bit is ever high; strobes never repeat while a button is held.
- WAIT:
  - busy=1; finished is registered.
  - Exit only on a finished rising edge (finished=1 and previous sample=0), so a stale high from a prior run is ignored. Go to DISP.
  - next presses are ignored.
- DISP:
  - disp=1 from the cycle after entry, held.
  - next press -> V0; disp drops the next cycle.
- clr press in any state -> V0 next cycle, with no strobe.
- clr and next pressed in the same cycle: clr wins.
- Wrap-around: DISP->V0 is the only cycle back. The datapath keeps its registers, so re-entry overwrites nibble by nibble.

Optional Feature:
Macro: AES_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT and clears on entry.
  - If it reaches TIMEOUT_CYCLES without a finished edge, the state goes to ERR and error=1.
  - In ERR, a next or clr press -> V0.
- Undefined: WAIT waits indefinitely; ERR is unreachable; error is tied 0.

Decomposition:
- Shared package: state encoding constants (V0..ERR), and step bit-index constants STEP_V0..STEP_START (0..13) so the wrapper glue maps bits by name.
- One sub-module is natural: btn_debounce (sync + counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated twice.

Test Plan:
Benches run with DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=32.
1. Reset release, no buttons -> state_idx=0 and all outputs 0 for 100 cycles.
2. btn_next bounces 1,0,1 for 2 cycles, then stays 1 for 10 cycles -> exactly one press. step=14'h0001 for one cycle (2+4+1 cycles after the stable start), then state_idx=1. Holding the button longer gives no further strobe.
3. Fourteen clean presses -> step shows bits 0..13 in order, one cycle each, never two bits high. After the 14th, state_idx=14 and busy=1.
4. In WAIT, finished already high from before start, then 0 for 3 cycles, then 1 -> state_idx=15 and disp=1 the cycle after the edge, busy=0. A next press then gives state_idx=0 and disp=0.
5. In K2, btn_next and btn_clr pressed together -> no strobe, state_idx=0. A separate test drops nrst while step[5] is high -> step clears combinationally with reset.
6. With AES_SEQ_TIMEOUT_EN defined, finished held 0 in WAIT -> after 32 cycles state_idx=16 and error=1; a clr press gives state_idx=0 and error=0. Without the macro, the same stimulus stays at state 14 for 1000 cycles.
